// File: rtl/sym_error_checker_pkg.sv
// Shared widths and FSM state encoding for the symbol error checker.
package sym_error_checker_pkg;

    localparam int LFSR_LEN   = 22;
    localparam int ASK4_SYM_W = 2;

    typedef enum logic {
        WAIT_START = 1'b0,
        ACCUM      = 1'b1
    } chk_state_t;

endpackage

// File: rtl/ref_sym_delay_line.sv
// Circular buffer aligning the transmit reference to the received symbol.
// Delay 0 bypasses the buffer; o_primed rises once DELAY_MAX symbols are stored.
module ref_sym_delay_line #(
    parameter int SYM_W     = 2,
    parameter int DELAY_MAX = 64,
    parameter int DLY_W     = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [SYM_W-1:0] i_tx_sym,
    input  logic [DLY_W-1:0] i_delay,
    output logic [SYM_W-1:0] o_ref_sym,
    output logic             o_primed
);

    logic [SYM_W-1:0] r_mem [DELAY_MAX];
    logic [DLY_W-1:0] r_wr_ptr;
    logic [DLY_W:0]   r_prime_cnt;
    logic [DLY_W-1:0] w_rd_ptr;

    // DELAY_MAX is a power of two, so the MSB alone marks a full count
    assign o_primed  = r_prime_cnt[DLY_W];
    assign w_rd_ptr  = r_wr_ptr - i_delay;
    assign o_ref_sym = (i_delay == '0) ? i_tx_sym : r_mem[w_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem       <= '{default: '0};
            r_wr_ptr    <= '0;
            r_prime_cnt <= '0;
        end else if (i_en) begin
            r_mem[r_wr_ptr] <= i_tx_sym;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            if (!o_primed)
                r_prime_cnt <= r_prime_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sym_error_checker.sv
// Per-rail symbol comparator with windowed symbol/error counting between
// LFSR period pulses; any delay change or clear abandons the open window.
module sym_error_checker
    import sym_error_checker_pkg::*;
#(
    parameter int SYM_W     = ASK4_SYM_W,
    parameter int DELAY_MAX = 64,
    parameter int DLY_W     = 6,
    parameter int CNT_W     = LFSR_LEN
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             sym_clk_en,
    input  logic [SYM_W-1:0] tx_sym,
    input  logic [SYM_W-1:0] rx_sym,
    input  logic [DLY_W-1:0] delay,
    input  logic             cycle_start,
    input  logic             clear,
    output logic [SYM_W-1:0] rx_data_out,
    output logic             rx_data_correct,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sym_count,
    output logic             count_valid,
    output logic             sat
);

    chk_state_t       r_state;
    logic [DLY_W-1:0] r_delay;
    logic [CNT_W-1:0] r_sym_acc;
    logic [CNT_W-1:0] r_err_acc;
    logic             r_win_sat;

    logic [SYM_W-1:0] w_ref_sym;
    logic             w_primed;
    logic             w_mismatch;
    logic             w_abort;

    ref_sym_delay_line #(
        .SYM_W    (SYM_W),
        .DELAY_MAX(DELAY_MAX),
        .DLY_W    (DLY_W)
    ) u_ref_dly (
        .i_clk    (sys_clk),
        .i_rst_n  (reset),
        .i_en     (sym_clk_en),
        .i_tx_sym (tx_sym),
        .i_delay  (delay),
        .o_ref_sym(w_ref_sym),
        .o_primed (w_primed)
    );

    assign w_mismatch = (rx_sym != w_ref_sym);
    assign w_abort    = clear | (delay != r_delay);

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state         <= WAIT_START;
            r_delay         <= '0;
            r_sym_acc       <= '0;
            r_err_acc       <= '0;
            r_win_sat       <= 1'b0;
            rx_data_out     <= '0;
            rx_data_correct <= 1'b0;
            err_count       <= '0;
            sym_count       <= '0;
            count_valid     <= 1'b0;
            sat             <= 1'b0;
        end else begin
            r_delay     <= delay;
            count_valid <= 1'b0;

            if (sym_clk_en) begin
                rx_data_out     <= rx_sym;
                rx_data_correct <= !w_mismatch;
            end

            // Abort outranks a coincident window boundary; published counts stay put
            if (w_abort) begin
                r_state <= WAIT_START;
            end else if (sym_clk_en) begin
                case (r_state)
                    WAIT_START: begin
                        if (cycle_start && w_primed) begin
                            r_state   <= ACCUM;
                            r_sym_acc <= CNT_W'(1);
                            r_err_acc <= CNT_W'(w_mismatch);
                            r_win_sat <= 1'b0;
                        end
                    end
                    ACCUM: begin
                        if (cycle_start) begin
                            err_count   <= r_err_acc;
                            sym_count   <= r_sym_acc;
                            sat         <= r_win_sat;
                            count_valid <= 1'b1;
                            r_sym_acc   <= CNT_W'(1);
                            r_err_acc   <= CNT_W'(w_mismatch);
                            r_win_sat   <= 1'b0;
                        end else begin
                            if (r_sym_acc == '1)
                                r_win_sat <= 1'b1;
                            else
                                r_sym_acc <= r_sym_acc + CNT_W'(1);
                            if (w_mismatch) begin
                                if (r_err_acc == '1)
                                    r_win_sat <= 1'b1;
                                else
                                    r_err_acc <= r_err_acc + CNT_W'(1);
                            end
                        end
                    end
                    default: r_state <= WAIT_START;
                endcase
            end
        end
    end

endmodule
